// File: rtl/kmeans_nearest_centroid_if.sv
// Handshake bundle for the K-means assignment stage.
//   cw_*      : centroid write port (controller -> stage)
//   in_*      : point input stream (valid/ready)
//   out_*     : result stream (valid/ready), nearest index + squared distance
//   busy      : stage has a point in flight
// master = controller/testbench side, slave = the assignment stage.
interface kmeans_nearest_centroid_if #(
    parameter int COORD_W = 15,
    parameter int IDX_W   = 4
);
    logic               cw_en;
    logic [IDX_W-1:0]   cw_idx;
    logic [COORD_W-1:0] cw_x;
    logic [COORD_W-1:0] cw_y;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [31:0]        out_dist;
    logic               out_none;

    modport master (
        output cw_en, cw_idx, cw_x, cw_y, in_valid, in_x, in_y, out_ready,
        input  busy, in_ready, out_valid, out_idx, out_dist, out_none
    );

    modport slave (
        input  cw_en, cw_idx, cw_x, cw_y, in_valid, in_x, in_y, out_ready,
        output busy, in_ready, out_valid, out_idx, out_dist, out_none
    );
endinterface

// File: rtl/kmeans_nearest_centroid.sv
// K-means assignment stage. Holds K 2-D centroids and, for each accepted
// point, walks the centroids one per cycle to find the nearest one by
// squared Euclidean distance.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : kmeans_nearest_centroid_if.slave (centroid writes, point in,
//           result out, busy)
// Timing: point accepted at edge E0 -> out_valid high after edge E0+K.
module kmeans_nearest_centroid #(
    parameter int K       = 4,
    parameter int COORD_W = 15,
    parameter int IDX_W   = 4
) (
    input  logic clk,
    input  logic reset,
    kmeans_nearest_centroid_if.slave bus
);
    localparam int PROD_W = 2 * COORD_W;
    localparam int D_W    = 2 * COORD_W + 1;
    // Storage is sized to the full index space so c_reg never indexes out
    // of range; slots >= K are never written and stay invalid.
    localparam int NSLOT  = 1 << IDX_W;
    localparam logic [IDX_W:0]   K_CMP = (IDX_W + 1)'(K);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(K - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   c_reg;
    logic [COORD_W-1:0] px_reg;
    logic [COORD_W-1:0] py_reg;
    logic [31:0]        best_dist_reg;
    logic [IDX_W-1:0]   best_idx_reg;
    logic               found_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               out_valid_reg;
    logic [IDX_W-1:0]   out_idx_reg;
    logic [31:0]        out_dist_reg;
    logic               out_none_reg;

    logic [COORD_W-1:0] cx_reg [NSLOT];
    logic [COORD_W-1:0] cy_reg [NSLOT];
    logic [NSLOT-1:0]   cvalid_reg;

    logic               wr_en;
    logic [COORD_W-1:0] cx_cur;
    logic [COORD_W-1:0] cy_cur;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [PROD_W-1:0]  dx_sq;
    logic [PROD_W-1:0]  dy_sq;
    logic [D_W-1:0]     d;
    logic [31:0]        d32;
    logic               take;
    logic [31:0]        best_dist_next;
    logic [IDX_W-1:0]   best_idx_next;
    logic               found_next;

    // Writes only land while idle, so the centroid set is frozen for the
    // whole scan of a point. A write on the accepting edge is still seen,
    // since the first comparison happens one edge later.
    assign wr_en = bus.cw_en && (state_reg == IDLE) && ({1'b0, bus.cw_idx} < K_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            cvalid_reg <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                cx_reg[i] <= '0;
                cy_reg[i] <= '0;
            end
        end else if (wr_en) begin
            cx_reg[bus.cw_idx]     <= bus.cw_x;
            cy_reg[bus.cw_idx]     <= bus.cw_y;
            cvalid_reg[bus.cw_idx] <= 1'b1;
        end
    end

    // Distance of the latched point to centroid c_reg. Widths are chosen so
    // the sum is exact: each square fits 2*COORD_W bits, the sum one more.
    always_comb begin
        cx_cur = cx_reg[c_reg];
        cy_cur = cy_reg[c_reg];
        dx     = (px_reg >= cx_cur) ? (px_reg - cx_cur) : (cx_cur - px_reg);
        dy     = (py_reg >= cy_cur) ? (py_reg - cy_cur) : (cy_cur - py_reg);
        dx_sq  = PROD_W'(dx) * PROD_W'(dx);
        dy_sq  = PROD_W'(dy) * PROD_W'(dy);
        d      = D_W'(dx_sq) + D_W'(dy_sq);
        d32    = 32'(d);
        // Strict less-than keeps the lower index on ties.
        take   = cvalid_reg[c_reg] && (!found_reg || (d32 < best_dist_reg));
        best_dist_next = take ? d32   : best_dist_reg;
        best_idx_next  = take ? c_reg : best_idx_reg;
        found_next     = found_reg | take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            c_reg         <= '0;
            px_reg        <= '0;
            py_reg        <= '0;
            best_dist_reg <= '1;
            best_idx_reg  <= '0;
            found_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_dist_reg  <= '0;
            out_none_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        px_reg        <= bus.in_x;
                        py_reg        <= bus.in_y;
                        c_reg         <= '0;
                        best_dist_reg <= '1;
                        best_idx_reg  <= '0;
                        found_reg     <= 1'b0;
                        in_ready_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= CALC;
                    end
                end
                CALC: begin
                    best_dist_reg <= best_dist_next;
                    best_idx_reg  <= best_idx_next;
                    found_reg     <= found_next;
                    c_reg         <= c_reg + 1'b1;
                    if (c_reg == LAST) begin
                        // With nothing found, best_* still hold their
                        // start values: index 0 and all-ones distance.
                        out_valid_reg <= 1'b1;
                        out_none_reg  <= ~found_next;
                        out_idx_reg   <= best_idx_next;
                        out_dist_reg  <= best_dist_next;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_dist  = out_dist_reg;
    assign bus.out_none  = out_none_reg;
endmodule
